div_pipe: RTL and testbench
===========================

# div_pipe

Pipelined signed integer divider, the inverse of the shift-add multiplier pipeline in the CNN datapath; used for average-pooling and requantization scaling. Accepts one DW-bit signed dividend/divisor pair per cycle and produces the truncated-toward-zero quotient and remainder DW cycles later through a DW-stage restoring-division pipeline. It follows the multiplier's handshake, with `en` in, `result_flag` out and `en_synch` as a synchronous pipeline flush, so both blocks drop into the same PE wrappers.

## Interface
- `DW`, default 8: operand, quotient and remainder width, two's complement; DW ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dividend`  in  DW  signed dividend.
- `divisor`  in  DW  signed divisor.
- `en`  in  1  input valid; operands are sampled on the edge where `en`=1.
- `en_synch`  in  1  synchronous enable; when 0, every stage is cleared on the next edge.
- `quotient`  out  DW  signed quotient, valid when `result_flag`=1.
- `remainder`  out  DW  signed remainder, valid when `result_flag`=1.
- `div_zero`  out  1  divisor was 0 for the result currently presented.
- `result_flag`  out  1  output valid.

## Operation
- **Front end (combinational):**
  - Magnitudes `|dividend|` and `|divisor|` are taken as DW-bit unsigned values; `|-2^(DW-1)|` = 2^(DW-1), which fits.
  - `q_sign` = dividend[DW-1] ^ divisor[DW-1].
  - `r_sign` = dividend[DW-1].
  - `dz` = (divisor == 0).
- **Stages:** stage i (0..DW-1) resolves quotient bit DW-1-i.
  - Shift the partial remainder left by 1 and bring in the next dividend magnitude bit.
  - Trial-subtract the divisor magnitude in DW+1 bits.
  - If the result is non-negative, keep the difference and set the quotient bit to 1. Otherwise restore the remainder and set the bit to 0.
- **Per-stage registers:** partial remainder (DW+1), divisor magnitude, remaining dividend bits, partial quotient, `q_sign`, `r_sign`, `dz`, and `valid`.
- **Register update rules:**
  - `valid[i]` loads `valid[i-1]` every edge; `valid[-1]` is `en`.
  - The data registers of stage i load only when `valid[i-1]`=1 and otherwise hold their value.
- **Back end (combinational from the last stage):**
  - quotient = `q_sign` ? −q_mag : q_mag, truncated to DW bits.
  - remainder = `r_sign` ? −r_mag : r_mag.
- **Signed overflow:** −2^(DW-1) / −1 yields q_mag = 2^(DW-1), which wraps to quotient = −2^(DW-1), with remainder 0. This is the required behaviour; no flag is raised.
- **Divide by zero:** when `dz`=1, the output forces quotient = −1 (all ones), remainder = dividend and `div_zero`=1. The pipeline still advances normally.
- `div_zero` is 0 whenever `result_flag`=0.
- **Flush:** `en_synch`=0 clears all `valid` bits and all data registers to 0 on the next edge and has priority over `en`.

## Timing
- **Reset:** `rst`=1 asynchronously clears all registers. While reset is held, `quotient`=0, `remainder`=0, `div_zero`=0 and `result_flag`=0.
- **Latency:** operands sampled on edge k appear with `result_flag`=1 after edge k+DW-1, which is DW edges total.
- **Throughput:** one result per cycle; there is no back-pressure.
- **No stalls:** back-to-back `en` pulses produce back-to-back results, and gaps in `en` produce matching gaps in `result_flag`.
- **Outputs are not held:** outputs change as the last stage updates, so a result is present for exactly one cycle per accepted input.
- **Mid-operation clear:** `en_synch` low or `rst` asserted mid-operation discards every in-flight operation; no partial result is ever flagged valid.
- **Restart after flush:** after `en_synch` returns to 1, the first new result needs the full DW cycles.

## Configuration
- `DIV_REM_OUT_EN` defined:
  - Remainder logic is compiled in.
  - The `remainder` port is driven as specified above.
- `DIV_REM_OUT_EN` undefined:
  - Remainder sign fix and remainder output mux are removed.
  - `remainder` is tied to 0.
  - The divide-by-zero case forces only the quotient.
  - Quotient, `div_zero`, `result_flag` and latency are identical in both builds.

## Test plan
- DW=8, single `en` pulse for each case:
  - 100/7 → quotient 14, remainder 2.
  - −100/7 → quotient −14, remainder −2.
  - 100/−7 → quotient −14, remainder 2.
  - `result_flag` rises exactly 8 edges after sampling.
- DW=8, corner cases:
  - −128/−1 → quotient −128, remainder 0, `div_zero`=0.
  - 127/1 → quotient 127, remainder 0.
  - 3/5 → quotient 0, remainder 3.
- DW=8, 5/0 → quotient −1, remainder 5, `div_zero`=1 for one cycle. Without `DIV_REM_OUT_EN`, remainder is 0.
- **Streaming:** 20 consecutive random operand pairs with `en` held high, then a 3-cycle gap, then 5 more. Results must match a reference model in order, one per cycle, and `result_flag` must show the same 3-cycle gap.
- **Flush:** drop `en_synch` to 0 for one cycle while 4 operations are in flight. `result_flag` must stay 0 for those operations, and the next input completes after the full 8 cycles.
- **Reset:** assert `rst` between clock edges mid-stream. All outputs go to 0 immediately, and after release no stale result appears.

Source files
------------

// File: rtl/div_pipe.sv
// Pipelined signed restoring divider: DW stages, one quotient bit per stage, truncating toward zero.
// Optional remainder output is compiled in when DIV_REM_OUT_EN is defined; otherwise remainder is tied to 0.
module div_pipe #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  input  logic          en,
  input  logic          en_synch,
  output logic [DW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          div_zero,
  output logic          result_flag
);

  logic [DW-1:0] mag_a, mag_b;
  logic          q_sign, r_sign, dz;

  // Negating -2^(DW-1) as unsigned gives 2^(DW-1), which still fits in DW bits.
  assign mag_a  = dividend[DW-1] ? -dividend : dividend;
  assign mag_b  = divisor[DW-1]  ? -divisor  : divisor;
  assign q_sign = dividend[DW-1] ^ divisor[DW-1];
  assign r_sign = dividend[DW-1];
  assign dz     = (divisor == '0);

  logic [DW:0]   rem_q [DW];
  logic [DW-1:0] dvs_q [DW];
  logic [DW-1:0] dvd_q [DW];
  logic [DW-1:0] quo_q [DW];
  logic          qs_q  [DW];
  logic          dz_q  [DW];
  logic          vld_q [DW];

  logic [DW:0]   src_rem [DW];
  logic [DW-1:0] src_dvs [DW];
  logic [DW-1:0] src_dvd [DW];
  logic [DW-1:0] src_quo [DW];
  logic          src_qs  [DW];
  logic          src_dz  [DW];
  logic          src_vld [DW];

  logic [DW:0]   sh      [DW];
  logic [DW:0]   tr      [DW];
  logic [DW:0]   nxt_rem [DW];
  logic [DW-1:0] nxt_quo [DW];

`ifdef DIV_REM_OUT_EN
  logic rs_q   [DW];
  logic src_rs [DW];
`endif

  always_comb begin
    src_rem[0] = '0;
    src_dvs[0] = mag_b;
    src_dvd[0] = mag_a;
    src_quo[0] = '0;
    src_qs[0]  = q_sign;
    src_dz[0]  = dz;
    src_vld[0] = en;
`ifdef DIV_REM_OUT_EN
    src_rs[0]  = r_sign;
`endif
    for (int i = 1; i < DW; i++) begin
      src_rem[i] = rem_q[i-1];
      src_dvs[i] = dvs_q[i-1];
      src_dvd[i] = dvd_q[i-1];
      src_quo[i] = quo_q[i-1];
      src_qs[i]  = qs_q[i-1];
      src_dz[i]  = dz_q[i-1];
      src_vld[i] = vld_q[i-1];
`ifdef DIV_REM_OUT_EN
      src_rs[i]  = rs_q[i-1];
`endif
    end
    // Bit DW of the trial difference is the borrow: set means restore.
    for (int i = 0; i < DW; i++) begin
      sh[i]      = (src_rem[i] << 1) | {{DW{1'b0}}, src_dvd[i][DW-1]};
      tr[i]      = sh[i] - {1'b0, src_dvs[i]};
      nxt_rem[i] = tr[i][DW] ? sh[i] : tr[i];
      nxt_quo[i] = (src_quo[i] << 1) | {{(DW-1){1'b0}}, ~tr[i][DW]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DW; i++) begin
        rem_q[i] <= '0;
        dvs_q[i] <= '0;
        dvd_q[i] <= '0;
        quo_q[i] <= '0;
        qs_q[i]  <= 1'b0;
        dz_q[i]  <= 1'b0;
        vld_q[i] <= 1'b0;
`ifdef DIV_REM_OUT_EN
        rs_q[i]  <= 1'b0;
`endif
      end
    end else if (!en_synch) begin
      for (int i = 0; i < DW; i++) begin
        rem_q[i] <= '0;
        dvs_q[i] <= '0;
        dvd_q[i] <= '0;
        quo_q[i] <= '0;
        qs_q[i]  <= 1'b0;
        dz_q[i]  <= 1'b0;
        vld_q[i] <= 1'b0;
`ifdef DIV_REM_OUT_EN
        rs_q[i]  <= 1'b0;
`endif
      end
    end else begin
      for (int i = 0; i < DW; i++) begin
        vld_q[i] <= src_vld[i];
        if (src_vld[i]) begin
          rem_q[i] <= nxt_rem[i];
          dvs_q[i] <= src_dvs[i];
          dvd_q[i] <= src_dvd[i] << 1;
          quo_q[i] <= nxt_quo[i];
          qs_q[i]  <= src_qs[i];
          dz_q[i]  <= src_dz[i];
`ifdef DIV_REM_OUT_EN
          rs_q[i]  <= src_rs[i];
`endif
        end
      end
    end
  end

  logic [DW-1:0] q_mag;
  assign q_mag = quo_q[DW-1];

  // With a zero divisor every trial succeeds, so the partial remainder ends as |dividend|.
  always_comb begin
    quotient = dz_q[DW-1] ? '1 : (qs_q[DW-1] ? -q_mag : q_mag);
`ifdef DIV_REM_OUT_EN
    remainder = rs_q[DW-1] ? -rem_q[DW-1][DW-1:0] : rem_q[DW-1][DW-1:0];
`else
    remainder = '0;
`endif
  end

  assign result_flag = vld_q[DW-1];
  assign div_zero    = vld_q[DW-1] & dz_q[DW-1];

endmodule

// File: tb/tb_div_pipe.sv
// Randomized and directed bench for div_pipe (DW=8) against a queue-based arithmetic reference model.
// Works in both builds; remainder expectations follow DIV_REM_OUT_EN.
module tb_div_pipe;
  localparam int DW = 8;
`ifdef DIV_REM_OUT_EN
  localparam bit REM_ON = 1'b1;
`else
  localparam bit REM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] dividend = '0;
  logic [DW-1:0] divisor = '0;
  logic          en = 1'b0;
  logic          en_synch = 1'b1;
  logic [DW-1:0] quotient, remainder;
  logic          div_zero, result_flag;

  div_pipe #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor),
    .en(en), .en_synch(en_synch), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .result_flag(result_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          dz;
  } exp_t;

  exp_t eq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] last_q, last_r;
  logic          last_dz;
  logic          exp_f;
  exp_t          e;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic exp_t model(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
    exp_t m;
    int ai, bi, qi, ri;
    ai = a;
    bi = b;
    m.due = 0;
    if (bi == 0) begin
      m.q  = '1;
      m.r  = REM_ON ? a : '0;
      m.dz = 1'b1;
    end else begin
      qi   = ai / bi;
      ri   = ai % bi;
      m.q  = qi[DW-1:0];
      m.r  = REM_ON ? ri[DW-1:0] : '0;
      m.dz = 1'b0;
    end
    return m;
  endfunction

  // Reference timing: an operand accepted at edge k is due at edge k+DW-1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      eq.delete();
    end else begin
      cyc++;
      if (!en_synch) eq.delete();
      else if (en) begin
        exp_t m;
        m = model(dividend, divisor);
        m.due = cyc + DW - 1;
        eq.push_back(m);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp_f = (eq.size() > 0) && (eq[0].due == cyc);
      chk("flag", {7'd0, result_flag}, {7'd0, exp_f});
      if (exp_f) begin
        e = eq.pop_front();
        chk("quot", quotient, e.q);
        chk("rem", remainder, e.r);
        chk("dz", {7'd0, div_zero}, {7'd0, e.dz});
      end else begin
        chk("dz_idle", {7'd0, div_zero}, 8'd0);
      end
      if (result_flag) begin
        last_q  = quotient;
        last_r  = remainder;
        last_dz = div_zero;
      end
    end
  end

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    en       = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  task automatic single(input logic [DW-1:0] a, input logic [DW-1:0] b);
    issue(a, b);
    idle(DW + 2);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_quot", quotient, 8'd0);
    chk("rst_rem", remainder, 8'd0);
    chk("rst_dz", {7'd0, div_zero}, 8'd0);
    chk("rst_flag", {7'd0, result_flag}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);

    single(8'd100, 8'd7);
    chk("q_100_7", last_q, 8'd14);
    chk("r_100_7", last_r, REM_ON ? 8'd2 : 8'd0);
    single(-8'sd100, 8'd7);
    chk("q_m100_7", last_q, 8'hF2);
    chk("r_m100_7", last_r, REM_ON ? 8'hFE : 8'd0);
    single(8'd100, -8'sd7);
    chk("q_100_m7", last_q, 8'hF2);
    chk("r_100_m7", last_r, REM_ON ? 8'd2 : 8'd0);
    single(8'h80, 8'hFF);
    chk("q_ovf", last_q, 8'h80);
    chk("r_ovf", last_r, 8'd0);
    chk("dz_ovf", {7'd0, last_dz}, 8'd0);
    single(8'd127, 8'd1);
    chk("q_127_1", last_q, 8'd127);
    single(8'd3, 8'd5);
    chk("q_3_5", last_q, 8'd0);
    chk("r_3_5", last_r, REM_ON ? 8'd3 : 8'd0);
    single(8'd5, 8'd0);
    chk("q_5_0", last_q, 8'hFF);
    chk("r_5_0", last_r, REM_ON ? 8'd5 : 8'd0);
    chk("dz_5_0", {7'd0, last_dz}, 8'd1);

    for (int i = 0; i < 20; i++) issue(8'($urandom), 8'($urandom));
    idle(3);
    for (int i = 0; i < 5; i++) issue(8'($urandom), 8'($urandom_range(0, 3)));
    idle(DW + 2);

    // Flush with en still high on the flush edge: en_synch wins.
    for (int i = 0; i < 4; i++) issue(8'($urandom), 8'($urandom));
    @(negedge clk);
    en_synch = 1'b0;
    en       = 1'b1;
    @(negedge clk);
    en_synch = 1'b1;
    en       = 1'b0;
    idle(2);
    single(8'd77, 8'd9);
    chk("q_after_flush", last_q, 8'd8);

    for (int i = 0; i < 6; i++) issue(8'($urandom), 8'($urandom));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_quot", quotient, 8'd0);
    chk("mid_rst_rem", remainder, 8'd0);
    chk("mid_rst_dz", {7'd0, div_zero}, 8'd0);
    chk("mid_rst_flag", {7'd0, result_flag}, 8'd0);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(DW + 3);

    for (int i = 0; i < 10; i++) issue(8'($urandom), 8'($urandom));
    idle(DW + 2);
    chk("queue_drained", 8'(eq.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
